// File: rtl/im_loader_pkg.sv
// im_loader_pkg: shared definitions for the instruction-memory loader.
//   - FSM state encodings (kept as plain localparams so older code can compare against them)
//   - IM geometry and base address (IM_BASE is also the PC reset value)
//   - insert_byte(): places one stream byte into a word lane
package im_loader_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RECV  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

    localparam int unsigned IM_WORDS = 1024;
    localparam logic [31:0] IM_BASE  = 32'h0000_0000;

    // Byte k of a word goes to lane 3-k in MIPS order, lane k otherwise.
    function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                                input logic [7:0]  b,
                                                input logic [1:0]  k,
                                                input logic        big_endian);
        logic [31:0] w;
        logic [1:0]  lane;
        w    = word;
        lane = big_endian ? ~k : k;
        case (lane)
            2'd0:    w[7:0]   = b;
            2'd1:    w[15:8]  = b;
            2'd2:    w[23:16] = b;
            default: w[31:24] = b;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/im_loader_byte_packer.sv
// im_loader_byte_packer: assembles four stream bytes into one 32-bit word.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   clr           clear byte counter and assembly register
//   shift_en      a byte transfer happens this cycle
//   byte_in       the byte being transferred
//   word_out      assembly register (stable while no transfer occurs)
//   word_full     this transfer completes the word (byte counter was 3)
module im_loader_byte_packer
    import im_loader_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_out,
    output logic        word_full
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;

    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clr) begin
            cnt_d  = 2'd0;
            word_d = 32'h0;
        end else if (shift_en) begin
            word_d = insert_byte(word_q, byte_in, cnt_q, BIG_ENDIAN);
            cnt_d  = cnt_q + 2'd1;  // wraps 3 -> 0 on the fourth byte
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= 2'd0;
            word_q <= 32'h0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    assign word_out  = word_q;
    assign word_full = shift_en && (cnt_q == 2'd3);

endmodule

// File: rtl/im_loader.sv
// im_loader: receives a program as a byte stream and writes it word by word into the
// instruction memory, holding the CPU in reset until the whole image is written.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   start, word_count         load request and program length in words
//   byte_valid, byte_data     byte source; byte_ready is the accept handshake
//   im_we, im_addr, im_din    IM write port (one pulse per word, word-aligned byte address)
//   busy, done, error         status (busy in RECV/WRITE)
//   cpu_hold                  fetcher/PC reset, released only in DONE
module im_loader
    import im_loader_pkg::*;
#(
    parameter int unsigned ADDR_W     = 10,
    parameter bit          BIG_ENDIAN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              im_we,
    output logic [31:0]       im_addr,
    output logic [31:0]       im_din,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_hold
);

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W:0]   len_q, len_d;

    logic        start_ok;
    logic        len_bad;
    logic        last_word;
    logic        shift_en;
    logic        word_full;
    logic [31:0] word;

    assign start_ok  = start && (state_q == ST_IDLE || state_q == ST_DONE ||
                                 state_q == ST_ERR);
    assign len_bad   = (word_count == '0) || (word_count > MAX_LEN);
    assign last_word = ({1'b0, idx_q} == (len_q - ONE));
    assign shift_en  = (state_q == ST_RECV) && byte_valid;

    im_loader_byte_packer #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (start_ok),
        .shift_en   (shift_en),
        .byte_in    (byte_data),
        .word_out   (word),
        .word_full  (word_full)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_ok) begin
                    if (len_bad) begin
                        state_d = ST_ERR;
                    end else begin
                        len_d   = word_count;
                        idx_d   = '0;
                        state_d = ST_RECV;
                    end
                end
            end
            ST_RECV: begin
                if (word_full) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (last_word) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_RECV;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
        end
    end

    // Moore decode: every output is a function of registered state only.
    assign byte_ready = (state_q == ST_RECV);
    assign im_we      = (state_q == ST_WRITE);
    assign im_addr    = IM_BASE + {{(30 - ADDR_W){1'b0}}, idx_q, 2'b00};
    assign im_din     = word;
    assign busy       = (state_q == ST_RECV) || (state_q == ST_WRITE);
    assign done       = (state_q == ST_DONE);
    assign error      = (state_q == ST_ERR);
    assign cpu_hold   = (state_q != ST_DONE);

endmodule

// File: tb/tb_im_loader.sv
module tb_im_loader;
    import im_loader_pkg::*;

    localparam int unsigned ADDR_W = 10;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   word_count;
    logic              byte_valid;
    logic [7:0]        byte_data;

    logic        byte_ready, im_we, busy, done, error, cpu_hold;
    logic [31:0] im_addr, im_din;
    logic        byte_ready_le, im_we_le, busy_le, done_le, error_le, cpu_hold_le;
    logic [31:0] im_addr_le, im_din_le;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    im_loader #(.ADDR_W(ADDR_W), .BIG_ENDIAN(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_count (word_count),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_din     (im_din),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .cpu_hold   (cpu_hold)
    );

    im_loader #(.ADDR_W(ADDR_W), .BIG_ENDIAN(1'b0)) dut_le (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_count (word_count),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready_le),
        .im_we      (im_we_le),
        .im_addr    (im_addr_le),
        .im_din     (im_din_le),
        .busy       (busy_le),
        .done       (done_le),
        .error      (error_le),
        .cpu_hold   (cpu_hold_le)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor on the big-endian instance.
    logic [31:0] wr_addr [0:1199];
    logic [31:0] wr_be   [0:1199];
    logic [31:0] wr_le   [0:1199];
    int wr_n         = 0;
    int rdy_in_write = 0;

    always @(negedge clk) begin
        if (im_we === 1'b1 && wr_n < 1200) begin
            wr_addr[wr_n] = im_addr;
            wr_be[wr_n]   = im_din;
            wr_le[wr_n]   = im_din_le;
            wr_n++;
        end
        if (im_we === 1'b1 && byte_ready !== 1'b0) rdy_in_write++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called and returns at a falling edge.
    task automatic do_start(input int unsigned n);
        start      = 1'b1;
        word_count = n[ADDR_W:0];
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int g;
        g          = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && g < 40) begin
            @(negedge clk);
            g++;
        end
        if (g >= 40) check("byte_ready_wait", {31'b0, byte_ready}, 32'h1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic send_word_be(input logic [31:0] w);
        for (int b = 0; b < 4; b++) send_byte(w[31 - 8 * b -: 8]);
    endtask

    logic [31:0] stall_words [0:2];
    int base, t0, t1, g, addr_bad, data_bad;
    logic [9:0]  kk;
    logic [31:0] exp_w;

    initial begin
        stall_words[0] = 32'h0123_4567;
        stall_words[1] = 32'h89AB_CDEF;
        stall_words[2] = 32'hDEAD_BEEF;
        rst = 1'b1; start = 1'b0; word_count = '0; byte_valid = 1'b0; byte_data = 8'h00;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_im_we",      {31'b0, im_we},      32'h0);
        check("rst_byte_ready", {31'b0, byte_ready}, 32'h0);
        check("rst_busy",       {31'b0, busy},       32'h0);
        check("rst_done",       {31'b0, done},       32'h0);
        check("rst_error",      {31'b0, error},      32'h0);
        check("rst_cpu_hold",   {31'b0, cpu_hold},   32'h1);
        check("rst_im_addr",    im_addr,             32'h0);
        check("rst_im_din",     im_din,              32'h0);
        check("rst_im_din_le",  im_din_le,           32'h0);
        rst = 1'b1;
        @(negedge clk);

        // Single word, big-endian
        do_start(1);
        check("w1_busy",       {31'b0, busy},       32'h1);
        check("w1_byte_ready", {31'b0, byte_ready}, 32'h1);
        send_byte(8'h8C); send_byte(8'h01); send_byte(8'h00); send_byte(8'h04);
        check("w1_im_we",      {31'b0, im_we},      32'h1);
        check("w1_im_addr",    im_addr,             32'h0);
        check("w1_im_din",     im_din,              32'h8C01_0004);
        check("w1_ready_wr",   {31'b0, byte_ready}, 32'h0);
        check("w1_cpu_hold",   {31'b0, cpu_hold},   32'h1);
        @(negedge clk);
        check("w1_done",       {31'b0, done},       32'h1);
        check("w1_cpu_hold2",  {31'b0, cpu_hold},   32'h0);
        check("w1_we_after",   {31'b0, im_we},      32'h0);
        check("w1_busy_after", {31'b0, busy},       32'h0);

        // Multi-word with two stall cycles between bytes
        base = wr_n;
        t0   = rdy_in_write;
        do_start(3);
        for (int w = 0; w < 3; w++) begin
            for (int b = 0; b < 4; b++) begin
                send_byte(stall_words[w][31 - 8 * b -: 8]);
                if (!(w == 2 && b == 3)) repeat (2) @(negedge clk);
            end
        end
        repeat (3) @(negedge clk);
        check("st_we_count", wr_n - base, 32'd3);
        for (int i = 0; i < 3; i++) begin
            check("st_addr",    wr_addr[base + i], 32'(i * 4));
            check("st_data_be", wr_be[base + i],   stall_words[i]);
            check("st_data_le", wr_le[base + i],   bswap(stall_words[i]));
        end
        check("st_ready_in_write", rdy_in_write - t0, 32'd0);
        check("st_done", {31'b0, done}, 32'h1);

        // Little-endian build
        do_start(1);
        send_byte(8'h04); send_byte(8'h00); send_byte(8'h01); send_byte(8'h8C);
        check("le_im_we",  {31'b0, im_we_le}, 32'h1);
        check("le_im_din", im_din_le,         32'h8C01_0004);
        check("le_be_din", im_din,            32'h0400_018C);
        @(negedge clk);
        check("le_done",   {31'b0, done_le},  32'h1);

        // Illegal lengths
        base = wr_n;
        do_start(0);
        check("len0_error",    {31'b0, error},      32'h1);
        check("len0_cpu_hold", {31'b0, cpu_hold},   32'h1);
        check("len0_done",     {31'b0, done},       32'h0);
        check("len0_busy",     {31'b0, busy},       32'h0);
        do_start(1025);
        check("len1025_error", {31'b0, error},      32'h1);
        byte_valid = 1'b1; byte_data = 8'h5A;
        repeat (3) @(negedge clk);
        check("err_ready",     {31'b0, byte_ready}, 32'h0);
        byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("err_no_we",     wr_n - base,         32'd0);
        do_start(1);
        check("rec_error_clr", {31'b0, error},      32'h0);
        check("rec_busy",      {31'b0, busy},       32'h1);
        send_word_be(32'hCAFE_BABE);
        check("rec_im_din",    im_din,              32'hCAFE_BABE);
        check("rec_im_addr",   im_addr,             32'h0);
        @(negedge clk);
        check("rec_done",      {31'b0, done},       32'h1);

        // Full image at full rate
        repeat (2) @(negedge clk);
        base = wr_n;
        do_start(IM_WORDS);
        t0 = cyc;
        for (int k = 0; k < int'(IM_WORDS); k++) begin
            kk = k[9:0];
            send_word_be({8'hA5, kk[7:0], 6'b0, kk[9:8], 8'h3C});
        end
        g = 0;
        while (done !== 1'b1 && g < 20) begin
            @(negedge clk);
            g++;
        end
        t1 = cyc;
        check("full_done",   {31'b0, done}, 32'h1);
        check("full_cycles", t1 - t0,       32'd5120);
        repeat (2) @(negedge clk);
        check("full_count",  wr_n - base,   32'd1024);
        check("full_first",  wr_addr[base], 32'h0);
        check("full_last",   wr_addr[base + 1023], 32'h0000_0FFC);
        addr_bad = 0;
        data_bad = 0;
        for (int k = 0; k < 1024; k++) begin
            kk    = k[9:0];
            exp_w = {8'hA5, kk[7:0], 6'b0, kk[9:8], 8'h3C};
            if (wr_addr[base + k] !== 32'(k * 4)) addr_bad++;
            if (wr_be[base + k] !== exp_w) data_bad++;
        end
        check("full_addr_seq", addr_bad, 32'd0);
        check("full_data",     data_bad, 32'd0);
        check("full_last_din", wr_be[base + 1023], 32'hA5FF_033C);

        // Reset mid-load; start during RECV is ignored
        base = wr_n;
        do_start(2);
        send_word_be(32'h1122_3344);
        send_byte(8'h55); send_byte(8'h66);
        start = 1'b1; word_count = '0;
        @(negedge clk);
        start = 1'b0;
        check("ign_error",      {31'b0, error},      32'h0);
        check("ign_busy",       {31'b0, busy},       32'h1);
        check("ign_ready",      {31'b0, byte_ready}, 32'h1);
        rst = 1'b0;
        #1;
        check("mid_im_we",      {31'b0, im_we},      32'h0);
        check("mid_busy",       {31'b0, busy},       32'h0);
        check("mid_cpu_hold",   {31'b0, cpu_hold},   32'h1);
        check("mid_im_din",     im_din,              32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_written",    wr_n - base,         32'd1);
        check("mid_word0",      wr_be[base],         32'h1122_3344);
        check("mid_idle_done",  {31'b0, done},       32'h0);
        do_start(1);
        send_word_be(32'h7788_99AA);
        check("post_im_din",    im_din,              32'h7788_99AA);
        check("post_im_addr",   im_addr,             32'h0);
        // Reset landing in a WRITE cycle must kill the pulse at once
        rst = 1'b0;
        #1;
        check("wr_rst_im_we",   {31'b0, im_we},      32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("wr_rst_hold",    {31'b0, cpu_hold},   32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
